// File: rtl/icache_sa.sv
// Purpose: set-associative read-only instruction cache between the IBus fetch
//          port and the CBus. Round-robin victim choice that prefers invalid
//          ways, a per-request uncached bypass, and a whole-cache flush.
// Latency: a hit returns data_ok 1 cycle after addr_ok. A miss takes the burst
//          time plus 2 cycles. An uncached read ends on the last CBus beat.
// Backpressure: only one request is accepted at a time, and only in IDLE. A
//          CBus beat is consumed only when icresp.ready is high. icreq stays
//          stable until the last beat.
// Ports:   clk, resetn (async active-low)
//          ireq/iresp   : IBus fetch request / response (addr_ok, data_ok, data)
//          icreq/icresp : CBus burst read request / response (ready, last, data)
//          nocache      : bypass the cache for the request being accepted
//          flush        : one-cycle pulse that invalidates every line

package icache_sa_pkg;
  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  // size is log2(bytes): 3'd2 means 4 bytes. len is the beat count itself.
  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [4:0]  len;
    logic [3:0]  strobe;
    logic [31:0] data;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;

  localparam logic [2:0] SIZE_4B = 3'd2;
endpackage

module icache_sa
  import icache_sa_pkg::*;
#(
  parameter int SET_NUM    = 16,
  parameter int WAY_NUM    = 2,
  parameter int LINE_WORDS = 16
) (
  input  logic       clk,
  input  logic       resetn,
  input  ibus_req_t  ireq,
  output ibus_resp_t iresp,
  output cbus_req_t  icreq,
  input  cbus_resp_t icresp,
  input  logic       nocache,
  input  logic       flush
);

  localparam int OB = $clog2(LINE_WORDS) + 2;
  localparam int IB = $clog2(SET_NUM);
  localparam int TB = 32 - OB - IB;
  // Word and way indices are widened to 1 bit for the degenerate sizes.
  // They then stay at zero.
  localparam int WB = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int RW = (WAY_NUM > 1) ? $clog2(WAY_NUM) : 1;

  typedef enum logic [1:0] {IDLE, LOOKUP, REFILL, UNCACHED} state_e;

  state_e          state_q, state_d;
  logic [31:0]     addr_q, addr_d;
  logic            flush_pend_q, flush_pend_d;
  logic [WB-1:0]   cnt_q, cnt_d;
  logic [RW-1:0]   victim_q, victim_d;

  logic [RW-1:0]      rr_q    [SET_NUM];
  logic [WAY_NUM-1:0] valid_q [SET_NUM];
  logic [TB-1:0]      tag_q   [WAY_NUM][SET_NUM];
  logic [31:0]        data_q  [WAY_NUM][SET_NUM][LINE_WORDS];

  // Split the latched address into its fields.
  logic [IB-1:0] idx;
  logic [TB-1:0] tag;
  logic [WB-1:0] word;

  assign idx  = addr_q[OB +: IB];
  assign tag  = addr_q[OB+IB +: TB];
  assign word = WB'((addr_q >> 2) & 32'(LINE_WORDS - 1));

  // Tag compare across every way of the indexed set.
  logic [WAY_NUM-1:0] hit_vec;
  logic [RW-1:0]      hit_way;
  logic               hit;

  always_comb begin
    hit_vec = '0;
    hit_way = '0;
    for (int w = 0; w < WAY_NUM; w++) begin
      hit_vec[w] = valid_q[idx][w] && (tag_q[w][idx] == tag);
      if (hit_vec[w]) hit_way = RW'(w);
    end
  end

  assign hit = |hit_vec;

  // Victim choice. The scan runs downward so that the lowest invalid way wins.
  // When no way is invalid, the set's round-robin pointer is used.
  logic [RW-1:0] victim_sel;

  always_comb begin
    victim_sel = rr_q[idx];
    for (int w = WAY_NUM - 1; w >= 0; w--) begin
      if (!valid_q[idx][w]) victim_sel = RW'(w);
    end
  end

  logic beat_last;
  assign beat_last = icresp.ready && icresp.last;

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (ireq.valid) state_d = nocache ? UNCACHED : LOOKUP;
      LOOKUP:   state_d = hit ? IDLE : REFILL;
      REFILL:   if (beat_last) state_d = LOOKUP;
      UNCACHED: if (beat_last) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    iresp = '0;
    icreq = '0;
    case (state_q)
      IDLE: begin
        // Gate addr_ok with resetn so that all outputs read 0 during reset.
        iresp.addr_ok = ireq.valid & resetn;
      end
      LOOKUP: begin
        if (hit) begin
          iresp.data_ok = 1'b1;
          iresp.data    = data_q[hit_way][idx][word];
        end
      end
      REFILL: begin
        icreq.valid = 1'b1;
        icreq.size  = SIZE_4B;
        icreq.addr  = {tag, idx, {OB{1'b0}}};
        icreq.len   = 5'(LINE_WORDS);
      end
      UNCACHED: begin
        icreq.valid = 1'b1;
        icreq.size  = SIZE_4B;
        icreq.addr  = addr_q;
        icreq.len   = 5'd1;
        if (beat_last) begin
          iresp.data_ok = 1'b1;
          iresp.data    = icresp.data;
        end
      end
      default: ;
    endcase
  end

  // A flush in IDLE clears all lines at once. A flush that arrives while busy
  // is held back until the FSM returns to IDLE, so the in-flight fetch still
  // completes. The line it just refilled is cleared too.
  logic leaving_busy, clear_all;
  assign leaving_busy = (state_q != IDLE) && (state_d == IDLE);
  assign clear_all    = ((state_q == IDLE) && flush) ||
                        (leaving_busy && (flush_pend_q || flush));

  always_comb begin
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    victim_d     = victim_q;
    flush_pend_d = flush_pend_q;
    if (state_q == IDLE && ireq.valid) addr_d = ireq.addr;
    if (state_q == LOOKUP) begin
      cnt_d = '0;
      if (!hit) victim_d = victim_sel;
    end
    if (state_q == REFILL && icresp.ready) cnt_d = cnt_q + 1'b1;
    if (clear_all)                         flush_pend_d = 1'b0;
    else if (state_q != IDLE && flush)     flush_pend_d = 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_q       <= '0;
      cnt_q        <= '0;
      victim_q     <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
      victim_q     <= victim_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  // Valid bits and round-robin pointers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int s = 0; s < SET_NUM; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else begin
      if (state_q == REFILL && beat_last) begin
        valid_q[idx][victim_q] <= 1'b1;
        if (victim_q == rr_q[idx])
          rr_q[idx] <= (WAY_NUM == 1) ? '0 : rr_q[idx] + 1'b1;
      end
      if (clear_all) begin
        for (int s = 0; s < SET_NUM; s++) valid_q[s] <= '0;
      end
    end
  end

  // Tag and data storage. These are not reset, because the valid bits
  // decide whether an entry is used.
  always_ff @(posedge clk) begin
    if (state_q == REFILL && icresp.ready) data_q[victim_q][idx][cnt_q] <= icresp.data;
    if (state_q == REFILL && beat_last)    tag_q[victim_q][idx]         <= tag;
  end

endmodule

// File: doc/icache_sa.md
Name: icache_sa

Overview:
- Dedicated set-associative, read-only instruction cache between the CPU fetch stage (IBus) and the cache bus (CBus).
- Replaces the DCache-proxy instruction cache with native parameters for sets, ways and line length.
- Adds a per-request uncached bypass, a whole-cache flush, and round-robin victim selection that prefers invalid ways.

Parameters:
- SET_NUM, 16, number of sets; power of 2, ≥2.
- WAY_NUM, 2, ways per set; power of 2, 1..8.
- LINE_WORDS, 16, 32-bit words per line; one of 1, 2, 4, 8, 16 (legal CBus burst lengths).

Ports:
- clk  input  1  clock
- resetn  input  1  asynchronous, active-low reset
- ireq  input  ibus_req_t  fetch request (valid, addr)
- iresp  output  ibus_resp_t  fetch response (addr_ok, data_ok, data)
- icreq  output  cbus_req_t  memory request toward the CBus arbiter
- icresp  input  cbus_resp_t  memory response (ready, last, data)
- nocache  input  1  current request is uncached; sampled together with addr_ok
- flush  input  1  one-cycle pulse: invalidate every line

Behaviour:
- Address split (32-bit): offset = addr[OB-1:0], OB = log2(LINE_WORDS)+2. index = next log2(SET_NUM) bits. tag = remaining upper bits. addr[1:0] is ignored for cached accesses.
- Storage: per-way valid/tag arrays and data arrays. Per-set round-robin pointer, log2(WAY_NUM) bits; zero-width when WAY_NUM=1.
- Reset (resetn low, asynchronous): state=IDLE; all valid bits=0; RR pointers=0; beat counter=0; flush-pending=0. All outputs 0, i.e. addr_ok, data_ok, data, icreq.valid.
- FSM states: IDLE, LOOKUP, REFILL, UNCACHED.
- IDLE
  - addr_ok = ireq.valid, combinationally.
  - On accept, latch addr and nocache. Go to UNCACHED if nocache=1, else LOOKUP.
  - No new accept outside IDLE. Master holds ireq stable until addr_ok.
- LOOKUP
  - Compare the latched tag against all valid ways of the indexed set.
  - Hit: data_ok=1 with the selected word this cycle, then go to IDLE. Hit latency is data_ok 1 cycle after addr_ok.
  - Miss: choose a victim, then go to REFILL with beat counter=0.
  - Victim rule: lowest-numbered invalid way if any exists, else the RR pointer way.
- REFILL
  - icreq.valid=1, is_write=0, size=4 bytes, addr={tag,index,OB'b0}, len=LINE_WORDS beats, strobe=0.
  - Request fields stay stable until the last beat.
  - Each cycle with icresp.ready: write icresp.data[31:0] into victim word[counter], then counter+1.
  - On ready&last: set victim valid, write tag. If the victim was the RR pointer way, advance the pointer by 1 (mod WAY_NUM). Go to LOOKUP; the retry then hits.
  - Miss latency = burst time + 2 cycles.
- UNCACHED
  - icreq: single beat, exact addr, size=4 bytes, len=1.
  - On ready&last: data_ok=1 with icresp.data[31:0], then go to IDLE.
  - No allocation and no tag/RR change, even if the line is present.
- flush
  - In IDLE: clear all valid bits next edge. A request accepted in the same cycle sees the flushed state (it lands in LOOKUP after the clear).
  - In any other state: set flush-pending. Clear all valids on the cycle the FSM next enters IDLE, including a line just refilled. The in-flight response is still delivered normally.
- data_ok is exactly one cycle per accepted request. iresp.data is valid only while data_ok=1, and is 0 otherwise.
- Reset asserted mid-REFILL abandons the burst; CBus-side recovery is the arbiter's responsibility.

Test Plan:
- Cold miss: after reset, fetch 0xBFC0_0004 cached. Expect a single 16-beat burst at 0xBFC0_0000; data_ok after the last beat with word 1. A following fetch 0xBFC0_0008 hits with data_ok exactly 1 cycle after addr_ok and no icreq.valid.
- Conflict/RR (SET_NUM=16, WAY_NUM=2, 64-byte lines): fetch 0x0000_0000, 0x0000_0400, 0x0000_0800, all mapping to index 0. The third access evicts way 0. Re-fetching 0x0000_0400 hits; 0x0000_0000 misses.
- Uncached: fetch 0xA000_0010 with nocache=1 twice. Expect two single-beat reads at 0xA000_0010 with len=1, and no tag change: a later cached fetch of 0x0000_0010's line still misses.
- Flush in IDLE: after the line 0x100 is resident, pulse flush, then fetch 0x104. Expect a refill burst at 0x100.
- Flush during REFILL: pulse flush at beat 5 of a refill. The response is still returned correctly; a subsequent fetch to the same line misses again.
- Backpressure: icresp.ready toggles 1-0-1 during the burst. Expect exactly 16 writes, correct word order, and icreq fields stable throughout.
